// File: rtl/aes_128_iter.sv
`default_nettype none
// ============================================================================
//  Module   : aes_128_iter
//  Purpose  : Iterative AES-128 encryption core. UNROLL rounds are evaluated
//             per clock, so one block needs 10/UNROLL RUN cycles. Input and
//             output use valid/ready handshakes with full output backpressure.
//  Ports    : clk_i        clock, all flops on posedge
//             rst_ni       asynchronous active-low reset
//             in_valid_i   plaintext/key present
//             in_ready_o   core can accept a block
//             in_bus_i     128-bit plaintext, byte 0 = [127:120]
//             key_i        128-bit cipher key, same byte order
//             out_valid_o  ciphertext present on out_bus_o
//             out_ready_i  sink accepts the ciphertext
//             out_bus_o    128-bit ciphertext
//             busy_o       core is not idle
//  Revision : 1.0  initial release
// ============================================================================
module aes_128_iter #(
    parameter int unsigned UNROLL   = 1,
    parameter bit          OUT_ZERO = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_bus_i,
    input  logic [127:0] key_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_bus_o,
    output logic         busy_o
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5) begin : g_bad_unroll
        $error("aes_128_iter: UNROLL must be 1, 2 or 5");
    end

    // Value of rnd at the start of the final RUN cycle (covers round 10).
    localparam logic [3:0] LAST_START = 4'(11 - UNROLL);
    localparam logic [3:0] UNROLL_W   = 4'(UNROLL);

    // Forward S-box, byte 0x00 at the most significant end.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Leaf transforms
    // ------------------------------------------------------------------
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = 11'd2047 - {x, 3'b000};
        return SBOX_TBL[idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    // Byte index is row + 4*column; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_schedule(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        // SubWord(RotWord(w3)) with the round constant folded into the top byte.
        t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Indexed by absolute round number, not by RUN cycle.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e       st_q,   st_d;
    logic [127:0] data_q, data_d;
    logic [127:0] key_q,  key_d;
    logic [3:0]   rnd_q,  rnd_d;
    logic         load;

    // ------------------------------------------------------------------
    // Unrolled round chain: stage g computes absolute round rnd_q + g.
    // ------------------------------------------------------------------
    logic [127:0] chain_st [UNROLL+1];
    logic [127:0] chain_rk [UNROLL+1];

    assign chain_st[0] = data_q;
    assign chain_rk[0] = key_q;

    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        logic [3:0]   rnd_abs;
        logic [127:0] sb_sr;
        assign rnd_abs         = rnd_q + 4'(g);
        assign sb_sr           = shift_rows(sub_bytes(chain_st[g]));
        assign chain_rk[g+1]   = key_schedule(chain_rk[g], rcon(rnd_abs));
        // The final round omits MixColumns.
        assign chain_st[g+1]   = ((rnd_abs == 4'd10) ? sb_sr : mix_columns(sb_sr)) ^ chain_rk[g+1];
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q   <= S_IDLE;
            data_q <= '0;
            key_q  <= '0;
            rnd_q  <= '0;
        end else begin
            st_q   <= st_d;
            data_q <= data_d;
            key_q  <= key_d;
            rnd_q  <= rnd_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        data_d = data_q;
        key_d  = key_q;
        rnd_d  = rnd_q;
        load   = 1'b0;
        case (st_q)
            S_IDLE: begin
                load = in_valid_i;
            end
            S_RUN: begin
                data_d = chain_st[UNROLL];
                key_d  = chain_rk[UNROLL];
                if (rnd_q == LAST_START) begin
                    // Park rnd at 10 so it never leaves the legal range.
                    rnd_d = 4'd10;
                    st_d  = S_DONE;
                end else begin
                    rnd_d = rnd_q + UNROLL_W;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    if (in_valid_i) begin
                        load = 1'b1;
                    end else begin
                        st_d = S_IDLE;
                    end
                end
            end
            default: begin
                st_d = S_IDLE;
            end
        endcase
        if (load) begin
            data_d = in_bus_i ^ key_i;
            key_d  = key_i;
            rnd_d  = 4'd1;
            st_d   = S_RUN;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Reset gating keeps in_ready low while the core is held in reset.
    assign in_ready_o  = rst_ni & ((st_q == S_IDLE) | ((st_q == S_DONE) & out_ready_i));
    assign out_valid_o = (st_q == S_DONE);
    assign busy_o      = (st_q != S_IDLE);

    if (OUT_ZERO) begin : g_out_zero
        assign out_bus_o = out_valid_o ? data_q : '0;
    end else begin : g_out_raw
        assign out_bus_o = data_q;
    end

    a_rnd_range : assert property (@(posedge clk_i) disable iff (!rst_ni) rnd_q <= 4'd10);

endmodule
`default_nettype wire
